// File: rtl/lfsr_checker.sv
// Checks an 8-bit Galois LFSR stream: searches for lock, flywheels while locked and flags errors.
// Optional saturating error counter enabled by defining LFSR_CHK_ERRCNT_EN.
module lfsr_checker #(
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample_valid,
    input  logic [7:0]  sample,
    input  logic        clr_err,
    output logic        locked,
    output logic        err_pulse,
    output logic        zero_err,
    output logic [15:0] err_count
);

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        LOCKED
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [7:0]  r_prev;
    logic [7:0]  w_prevNext;
    logic [3:0]  r_run;
    logic [3:0]  w_runNext;
    logic [3:0]  r_miss;
    logic [3:0]  w_missNext;
    logic        r_errPulse;
    logic        r_zeroErr;
    logic        w_errPulseNext;
    logic        w_zeroErrNext;
    logic [7:0]  w_expected;
    logic        w_match;
    logic        w_isZero;
    logic [3:0]  w_runInc;
    logic [3:0]  w_missInc;

    assign w_expected = {r_prev[6], r_prev[5], r_prev[4],
                         r_prev[3] ^ r_prev[7], r_prev[2] ^ r_prev[7],
                         r_prev[1] ^ r_prev[7], r_prev[0], r_prev[7]};
    assign w_match    = (sample == w_expected);
    assign w_isZero   = (sample == 8'h00);
    assign w_runInc   = r_run + 4'd1;
    assign w_missInc  = r_miss + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_prev     <= 8'h00;
            r_run      <= 4'd0;
            r_miss     <= 4'd0;
            r_errPulse <= 1'b0;
            r_zeroErr  <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_prev     <= w_prevNext;
            r_run      <= w_runNext;
            r_miss     <= w_missNext;
            r_errPulse <= w_errPulseNext;
            r_zeroErr  <= w_zeroErrNext;
        end
    end

    // A zero word can never be part of the sequence, so it takes priority in IDLE and SEARCH
    always_comb begin
        w_nextState    = r_state;
        w_prevNext     = r_prev;
        w_runNext      = r_run;
        w_missNext     = r_miss;
        w_errPulseNext = 1'b0;
        w_zeroErrNext  = 1'b0;
        if (sample_valid) begin
            case (r_state)
                IDLE: begin
                    if (w_isZero) begin
                        w_zeroErrNext = 1'b1;
                    end else begin
                        w_prevNext  = sample;
                        w_runNext   = 4'd0;
                        w_nextState = SEARCH;
                    end
                end
                SEARCH: begin
                    if (w_isZero) begin
                        w_zeroErrNext = 1'b1;
                        w_nextState   = IDLE;
                    end else if (w_match) begin
                        w_runNext  = w_runInc;
                        w_prevNext = sample;
                        if (w_runInc == 4'(LOCK_COUNT)) begin
                            w_nextState = LOCKED;
                            w_missNext  = 4'd0;
                        end
                    end else begin
                        w_prevNext = sample;
                        w_runNext  = 4'd0;
                    end
                end
                LOCKED: begin
                    // Flywheel on the predicted word so a single bad word costs one error
                    w_prevNext = w_expected;
                    if (w_match) begin
                        w_missNext = 4'd0;
                    end else begin
                        w_errPulseNext = 1'b1;
                        w_zeroErrNext  = w_isZero;
                        w_missNext     = w_missInc;
                        if (w_missInc == 4'(LOSS_COUNT)) begin
                            w_nextState = SEARCH;
                            w_runNext   = 4'd0;
                            w_prevNext  = sample;
                        end
                    end
                end
                default: begin
                    w_nextState = IDLE;
                end
            endcase
        end
    end

    assign locked    = (r_state == LOCKED);
    assign err_pulse = r_errPulse;
    assign zero_err  = r_zeroErr;

`ifdef LFSR_CHK_ERRCNT_EN
    logic [15:0] r_errCount;
    logic        w_errInc;

    assign w_errInc = sample_valid && (r_state == LOCKED) && !w_match;

    // Clear beats a same-cycle increment; the count sticks at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_errCount <= 16'h0000;
        end else if (clr_err) begin
            r_errCount <= 16'h0000;
        end else if (w_errInc && (r_errCount != 16'hFFFF)) begin
            r_errCount <= r_errCount + 16'd1;
        end
    end

    assign err_count = r_errCount;
`else
    logic w_unused;

    assign w_unused  = clr_err;
    assign err_count = 16'h0000;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Randomized scoreboard bench for lfsr_checker; follows LFSR_CHK_ERRCNT_EN like the design.
module tb_lfsr_checker;

    logic        clk;
    logic        rst_n;
    logic        sample_valid;
    logic [7:0]  sample;
    logic        clr_err;
    logic        locked;
    logic        err_pulse;
    logic        zero_err;
    logic [15:0] err_count;

    localparam int LOCK_N = 4;
    localparam int LOSS_N = 3;
`ifdef LFSR_CHK_ERRCNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    typedef struct {
        logic        locked;
        logic        errp;
        logic        zero;
        logic [15:0] cnt;
    } expT;

    expT sbQ[$];
    int  vecCount  = 0;
    int  missCount = 0;

    // Reference model state: mode 0 = idle, 1 = search, 2 = locked
    int         mMode;
    logic [7:0] mPrev;
    int         mRun;
    int         mMiss;
    int         mCnt;

    lfsr_checker #(.LOCK_COUNT(LOCK_N), .LOSS_COUNT(LOSS_N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .sample       (sample),
        .clr_err      (clr_err),
        .locked       (locked),
        .err_pulse    (err_pulse),
        .zero_err     (zero_err),
        .err_count    (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running, required finished");
        $fatal(1, "[TB] watchdog");
    end

    // Galois step: rotate left, and fold the outgoing MSB into taps 2..4
    function automatic logic [7:0] nextWord(input logic [7:0] p);
        logic [7:0] r;
        r = {p[6:0], p[7]};
        if (p[7]) r = r ^ 8'h1C;
        return r;
    endfunction

    task automatic modelReset();
        mMode = 0;
        mPrev = 8'h00;
        mRun  = 0;
        mMiss = 0;
        mCnt  = 0;
    endtask

    task automatic countError();
        if (CNT_ON && mCnt < 65535) mCnt = mCnt + 1;
    endtask

    task automatic modelStep(input logic v, input logic [7:0] s, input logic c, output expT e);
        logic [7:0] predicted;
        e.errp = 1'b0;
        e.zero = 1'b0;
        if (v) begin
            predicted = nextWord(mPrev);
            if (mMode == 0) begin
                if (s == 8'h00) e.zero = 1'b1;
                else begin
                    mPrev = s;
                    mRun  = 0;
                    mMode = 1;
                end
            end else if (mMode == 1) begin
                if (s == 8'h00) begin
                    e.zero = 1'b1;
                    mMode  = 0;
                end else if (s == predicted) begin
                    mRun  = mRun + 1;
                    mPrev = s;
                    if (mRun == LOCK_N) begin
                        mMode = 2;
                        mMiss = 0;
                    end
                end else begin
                    mPrev = s;
                    mRun  = 0;
                end
            end else begin
                mPrev = predicted;
                if (s == predicted) mMiss = 0;
                else begin
                    e.errp = 1'b1;
                    e.zero = (s == 8'h00);
                    countError();
                    mMiss = mMiss + 1;
                    if (mMiss == LOSS_N) begin
                        mMode = 1;
                        mRun  = 0;
                        mPrev = s;
                    end
                end
            end
        end
        if (c) mCnt = 0;
        e.locked = (mMode == 2);
        e.cnt    = 16'(mCnt);
    endtask

    // Monitor: the DUT presents a registered response one edge after each issued cycle
    always @(posedge clk) begin
        expT e;
        #1;
        if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            vecCount = vecCount + 1;
            if (locked !== e.locked || err_pulse !== e.errp || zero_err !== e.zero || err_count !== e.cnt) begin
                missCount = missCount + 1;
                $display("[TB] FAIL scoreboard t=%0t got locked=%b err_pulse=%b zero_err=%b err_count=%0d, expected %b %b %b %0d",
                         $time, locked, err_pulse, zero_err, err_count, e.locked, e.errp, e.zero, e.cnt);
            end
        end
    end

    task automatic applyStimulus(input logic v, input logic [7:0] s, input logic c);
        expT e;
        @(negedge clk);
        sample_valid = v;
        sample       = s;
        clr_err      = c;
        modelStep(v, s, c, e);
        sbQ.push_back(e);
        @(posedge clk);
        #2;
        sample_valid = 1'b0;
        clr_err      = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        vecCount = vecCount + 1;
        if (actual !== expected) begin
            missCount = missCount + 1;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    initial begin
        logic [7:0] w;
        logic [7:0] c;
        logic [7:0] txWord;
        int         r;
        sample_valid = 1'b0;
        sample       = 8'h00;
        clr_err      = 1'b0;
        rst_n        = 1'b1;
        modelReset();
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset_locked", {15'd0, locked}, 16'd0);
        checkOutput("reset_err_pulse", {15'd0, err_pulse}, 16'd0);
        checkOutput("reset_zero_err", {15'd0, zero_err}, 16'd0);
        checkOutput("reset_err_count", err_count, 16'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Zero word while idle
        applyStimulus(1'b1, 8'h00, 1'b0);
        checkOutput("idle_zero_pulse", {15'd0, zero_err}, 16'd1);
        checkOutput("idle_zero_unlocked", {15'd0, locked}, 16'd0);
        applyStimulus(1'b0, 8'h55, 1'b0);
        checkOutput("idle_zero_one_cycle", {15'd0, zero_err}, 16'd0);

        // Acquire lock from 0xFF, 0xE3, ...
        w = 8'hFF;
        applyStimulus(1'b1, w, 1'b0);
        for (int i = 0; i < 4; i++) begin
            w = nextWord(w);
            if (i == 0) checkOutput("first_step_e3", {8'd0, w}, 16'h00E3);
            applyStimulus(1'b1, w, 1'b0);
            if (i == 2) checkOutput("lock_not_early", {15'd0, locked}, 16'd0);
        end
        checkOutput("lock_after_5th", {15'd0, locked}, 16'd1);

        // Single corrupted word
        w = nextWord(w);
        applyStimulus(1'b1, w ^ 8'h01, 1'b0);
        checkOutput("bit0_err_pulse", {15'd0, err_pulse}, 16'd1);
        checkOutput("bit0_err_count", err_count, CNT_ON ? 16'd1 : 16'd0);
        w = nextWord(w);
        applyStimulus(1'b1, w, 1'b0);
        checkOutput("bit0_pulse_one_cycle", {15'd0, err_pulse}, 16'd0);
        checkOutput("bit0_still_locked", {15'd0, locked}, 16'd1);

        // Zero word while locked
        w = nextWord(w);
        applyStimulus(1'b1, 8'h00, 1'b0);
        checkOutput("locked_zero_zero_err", {15'd0, zero_err}, 16'd1);
        checkOutput("locked_zero_err_pulse", {15'd0, err_pulse}, 16'd1);
        w = nextWord(w);
        applyStimulus(1'b1, w, 1'b0);

        // Three consecutive bad words drop lock, then relock from the last one
        c = 8'h00;
        for (int k = 0; k < 3; k++) begin
            w = nextWord(w);
            c = w ^ 8'h10;
            if (c == 8'h00) c = w ^ 8'h30;
            applyStimulus(1'b1, c, 1'b0);
            if (k == 1) checkOutput("loss_not_early", {15'd0, locked}, 16'd1);
        end
        checkOutput("loss_after_3rd", {15'd0, locked}, 16'd0);
        checkOutput("loss_err_count", err_count, CNT_ON ? 16'd5 : 16'd0);
        w = c;
        for (int k = 0; k < 4; k++) begin
            w = nextWord(w);
            applyStimulus(1'b1, w, 1'b0);
        end
        checkOutput("relock", {15'd0, locked}, 16'd1);

        // Clear coincident with a locked mismatch
        w = nextWord(w);
        applyStimulus(1'b1, w ^ 8'h04, 1'b1);
        checkOutput("clr_wins_count", err_count, 16'd0);
        checkOutput("clr_wins_pulse", {15'd0, err_pulse}, 16'd1);
        w = nextWord(w);
        applyStimulus(1'b1, w, 1'b0);

        // Asynchronous reset while locked
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midlock_reset_locked", {15'd0, locked}, 16'd0);
        checkOutput("midlock_reset_err_count", err_count, 16'd0);
        checkOutput("midlock_reset_flags", {14'd0, err_pulse, zero_err}, 16'd0);
        modelReset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Random traffic: mostly clean stream with corruptions, zeros, restarts, gaps and clears
        txWord = 8'(($urandom_range(1, 255)));
        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 15) begin
                applyStimulus(1'b0, 8'($urandom), ($urandom_range(0, 29) == 0));
            end else begin
                txWord = nextWord(txWord);
                r = int'($urandom_range(0, 99));
                if (r < 82) c = txWord;
                else if (r < 92) c = txWord ^ 8'($urandom_range(1, 255));
                else if (r < 95) c = 8'h00;
                else begin
                    c = 8'($urandom_range(1, 255));
                    txWord = c;
                end
                applyStimulus(1'b1, c, ($urandom_range(0, 49) == 0));
            end
        end

        repeat (2) @(negedge clk);
        if (sbQ.size() != 0) begin
            missCount = missCount + 1;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sbQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
